// File: rtl/exec_ctrl_fsm_if.sv
// Data-memory request/acknowledge bus between exec_ctrl_fsm (master) and data memory (slave).
interface exec_ctrl_fsm_if #(
  parameter int XLEN = 32
) ();
  logic                mem_req;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_be;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/exec_ctrl_fsm.sv
// Multi-cycle execute/memory/writeback controller (IDLE -> EXEC -> [MEM] -> WB).
// Optional feature macro MISALIGN_TRAP_EN: trap misaligned accesses and jump targets.
module exec_ctrl_fsm #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_en,
  exec_ctrl_fsm_if.master mem,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic            jump_en,
  output logic [XLEN-1:0] jump_target,
  output logic            done,
  output logic            mem_err,
  output logic            illegal,
  output logic            misalign
);
  localparam int BW = XLEN / 8;
  localparam int LW = $clog2(BW);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_e;

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
  logic [XLEN-1:0] res_q, res_d, tgt_q, tgt_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic            we_q, we_d, wr_q, wr_d, jmp_q, jmp_d;
  logic            ill_q, ill_d, mis_q, mis_d, err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] sum_s, pcimm_s, pc4_s;
  logic            taken_s, alu_en_s;

  function automatic logic ls_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: ls_legal = 1'b1;
      3'b011:                 ls_legal = (XLEN == 64);
      3'b100, 3'b101:         ls_legal = !is_store;
      3'b110:                 ls_legal = !is_store && (XLEN == 64);
      default:                ls_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [XLEN-1:0] a);
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a[1:0];
      default: misaligned = |a[2:0];
    endcase
  endfunction

  // Shift the addressed lane down, then sign- or zero-extend by access size.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] data,
                                               input logic [2:0] f3,
                                               input logic [LW-1:0] lane);
    logic [XLEN-1:0] sh;
    sh = data >> {lane, 3'b000};
    case (f3)
      3'b000:  load_ext = XLEN'(signed'(sh[7:0]));
      3'b001:  load_ext = XLEN'(signed'(sh[15:0]));
      3'b010:  load_ext = XLEN'(signed'(sh[31:0]));
      3'b100:  load_ext = XLEN'(sh[7:0]);
      3'b101:  load_ext = XLEN'(sh[15:0]);
      3'b110:  load_ext = XLEN'(sh[31:0]);
      default: load_ext = sh;
    endcase
  endfunction

  // Next-state and datapath-register computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    f3_d     = f3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    res_d    = res_q;
    tgt_d    = tgt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    wr_d     = wr_q;
    jmp_d    = jmp_q;
    ill_d    = ill_q;
    mis_d    = mis_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    alu_en_s = 1'b0;
    taken_s  = 1'b0;
    sum_s    = rs1_q + imm_q;
    pcimm_s  = pc_q + imm_q;
    pc4_s    = pc_q + PC_STEP;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          f3_d    = funct3;
          rs1_d   = rs1_val;
          rs2_d   = rs2_val;
          imm_d   = imm;
          pc_d    = pc;
          wr_d    = 1'b0;
          jmp_d   = 1'b0;
          ill_d   = 1'b0;
          mis_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op_q)
          OP_REG, OP_IMM: begin
            alu_en_s = 1'b1;
            res_d    = alu_result;
            wr_d     = 1'b1;
          end
          OP_LUI: begin
            res_d = imm_q;
            wr_d  = 1'b1;
          end
          OP_AUIPC: begin
            res_d = pcimm_s;
            wr_d  = 1'b1;
          end
          OP_JAL: begin
            res_d = pc4_s;
            wr_d  = 1'b1;
            jmp_d = 1'b1;
            tgt_d = pcimm_s;
          end
          OP_JALR: begin
            if (f3_q == 3'b000) begin
              res_d = pc4_s;
              wr_d  = 1'b1;
              jmp_d = 1'b1;
              tgt_d = {sum_s[XLEN-1:1], 1'b0};
            end else begin
              ill_d = 1'b1;
            end
          end
          OP_BR: begin
            case (f3_q)
              3'b000:  taken_s = (rs1_q == rs2_q);
              3'b001:  taken_s = (rs1_q != rs2_q);
              3'b100:  taken_s = ($signed(rs1_q) <  $signed(rs2_q));
              3'b101:  taken_s = ($signed(rs1_q) >= $signed(rs2_q));
              3'b110:  taken_s = (rs1_q <  rs2_q);
              3'b111:  taken_s = (rs1_q >= rs2_q);
              default: ill_d   = 1'b1;
            endcase
            jmp_d = taken_s;
            tgt_d = pcimm_s;
          end
          OP_LOAD, OP_STORE: begin
            if (ls_legal(op_q == OP_STORE, f3_q)) begin
              addr_d = sum_s;
              we_d   = (op_q == OP_STORE);
              cnt_d  = 32'd0;
              case (f3_q[1:0])
                2'b00: begin
                  be_d    = BW'(8'h01) << sum_s[LW-1:0];
                  wdata_d = {BW{rs2_q[7:0]}};
                end
                2'b01: begin
                  be_d    = BW'(8'h03) << sum_s[LW-1:0];
                  wdata_d = {(XLEN/16){rs2_q[15:0]}};
                end
                2'b10: begin
                  be_d    = BW'(8'h0F) << sum_s[LW-1:0];
                  wdata_d = {(XLEN/32){rs2_q[31:0]}};
                end
                default: begin
                  be_d    = BW'(8'hFF) << sum_s[LW-1:0];
                  wdata_d = rs2_q;
                end
              endcase
              state_d = S_MEM;
            end else begin
              ill_d = 1'b1;
            end
          end
          default: ill_d = 1'b1;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((jmp_d && tgt_d[1]) ||
            ((op_q == OP_LOAD || op_q == OP_STORE) &&
             ls_legal(op_q == OP_STORE, f3_q) && misaligned(f3_q, sum_s))) begin
          mis_d   = 1'b1;
          jmp_d   = 1'b0;
          wr_d    = 1'b0;
          state_d = S_WB;
        end else begin
          mis_d = 1'b0;
        end
`endif
      end
      S_MEM: begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (mem.mem_ack) begin
          wr_d    = !we_q;
          res_d   = load_ext(mem.mem_rdata, f3_q, addr_q[LW-1:0]);
          state_d = S_WB;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == 32'(MEM_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          wr_d    = 1'b0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      res_q   <= '0;
      tgt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wr_q    <= 1'b0;
      jmp_q   <= 1'b0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      res_q   <= res_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      jmp_q   <= jmp_d;
      ill_q   <= ill_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign alu_en        = alu_en_s;
  assign mem.mem_req   = (state_q == S_MEM);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign rf_we         = (state_q == S_WB) && wr_q;
  assign rf_wdata      = res_q;
  assign jump_en       = (state_q == S_WB) && jmp_q;
  assign jump_target   = tgt_q;
  assign done          = (state_q == S_WB);
  assign mem_err       = (state_q == S_WB) && err_q;
  assign illegal       = (state_q == S_WB) && ill_q;
  assign misalign      = (state_q == S_WB) && mis_q;
endmodule

// File: tb/tb_exec_ctrl_fsm.sv
// Directed scoreboard bench for exec_ctrl_fsm (XLEN=32, MEM_TIMEOUT=4); honours MISALIGN_TRAP_EN.
module tb_exec_ctrl_fsm;
  localparam int XLEN = 32;
  localparam int TMO  = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [6:0]      opcode = 7'd0;
  logic [2:0]      funct3 = 3'd0;
  logic [XLEN-1:0] rs1_val = '0, rs2_val = '0, imm = '0, pc = '0, alu_result = '0;
  logic            alu_en, rf_we, jump_en, done, mem_err, illegal, misalign;
  logic [XLEN-1:0] rf_wdata, jump_target;

  exec_ctrl_fsm_if #(.XLEN(XLEN)) mem_if ();

  exec_ctrl_fsm #(.XLEN(XLEN), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .pc(pc), .alu_result(alu_result), .alu_en(alu_en), .mem(mem_if),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .jump_en(jump_en), .jump_target(jump_target),
    .done(done), .mem_err(mem_err), .illegal(illegal), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rf_we;
    logic [31:0] wdata;
    logic        jmp;
    logic [31:0] tgt;
    logic        ill;
    logic        err;
    logic        mis;
    logic        alu;
    int          lat;
    int          reqs;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] mwdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", name, obs, want);
    end
  endtask

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.tag = tag; e.rf_we = 1'b0; e.wdata = 32'd0; e.jmp = 1'b0; e.tgt = 32'd0;
    e.ill = 1'b0; e.err = 1'b0; e.mis = 1'b0; e.alu = 1'b0; e.lat = 2; e.reqs = 0;
    e.we = 1'b0; e.be = 4'd0; e.addr = 32'd0; e.mwdata = 32'd0;
    return e;
  endfunction

  // Issue one instruction, act as memory (ack on request cycle index ack_at, -1 = never), score at done.
  task automatic run(input exp_t e, input logic [6:0] op, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                     input logic [31:0] p, input logic [31:0] alu, input int ack_at,
                     input logic [31:0] rdata);
    exp_t x;
    int cyc, reqs;
    logic got, saw_alu, m_we;
    logic [3:0] m_be;
    logic [31:0] m_addr, m_wd;
    exp_q.push_back(e);
    chk({e.tag, ".ready_idle"}, instr_ready, 1'b1);
    opcode = op; funct3 = f3; rs1_val = a; rs2_val = b; imm = im; pc = p; alu_result = alu;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    cyc = 1; reqs = 0; got = 1'b0; m_we = 1'b0; m_be = 4'd0; m_addr = 32'd0; m_wd = 32'd0;
    saw_alu = alu_en;
    chk({e.tag, ".ready_busy"}, instr_ready, 1'b0);
    while (!got && cyc < 40) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (mem_if.mem_req) begin
          if (reqs == 0) begin
            m_we = mem_if.mem_we; m_be = mem_if.mem_be;
            m_addr = mem_if.mem_addr; m_wd = mem_if.mem_wdata;
          end
          mem_if.mem_ack = (reqs == ack_at);
          mem_if.mem_rdata = rdata;
          reqs++;
        end
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        cyc++;
      end
    end
    chk({e.tag, ".done_seen"}, got, 1'b1);
    x = exp_q.pop_front();
    chk({x.tag, ".latency"}, cyc, x.lat);
    chk({x.tag, ".req_cycles"}, reqs, x.reqs);
    chk({x.tag, ".alu_en"}, saw_alu, x.alu);
    chk({x.tag, ".rf_we"}, rf_we, x.rf_we);
    if (x.rf_we) chk({x.tag, ".rf_wdata"}, rf_wdata, x.wdata);
    chk({x.tag, ".jump_en"}, jump_en, x.jmp);
    if (x.jmp) chk({x.tag, ".jump_target"}, jump_target, x.tgt);
    chk({x.tag, ".illegal"}, illegal, x.ill);
    chk({x.tag, ".mem_err"}, mem_err, x.err);
    chk({x.tag, ".misalign"}, misalign, x.mis);
    if (x.reqs > 0) begin
      chk({x.tag, ".mem_we"}, m_we, x.we);
      chk({x.tag, ".mem_be"}, m_be, x.be);
      chk({x.tag, ".mem_addr"}, m_addr, x.addr);
      chk({x.tag, ".mem_wdata"}, m_wd, x.mwdata);
    end
    @(posedge clk); #1;
    chk({x.tag, ".done_pulse"}, done, 1'b0);
    chk({x.tag, ".rf_we_pulse"}, rf_we, 1'b0);
    chk({x.tag, ".ready_back"}, instr_ready, 1'b1);
  endtask

  initial begin
    exp_t e;
    int n;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.ready", instr_ready, 1'b1);
    chk("reset.req", mem_if.mem_req, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.rf_we", rf_we, 1'b0);
    chk("reset.jump_en", jump_en, 1'b0);
    chk("reset.alu_en", alu_en, 1'b0);
    chk("reset.mem_be", mem_if.mem_be, 4'd0);

    e = blank("add"); e.rf_we = 1'b1; e.wdata = 32'h0000_1234; e.alu = 1'b1;
    run(e, OP_REG, 3'b000, 32'h1000, 32'h0234, 32'd0, 32'h0, 32'h0000_1234, -1, 32'd0);

    e = blank("blt"); e.jmp = 1'b1; e.tgt = 32'h120;
    run(e, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, -1, 32'd0);
    e = blank("bltu");
    run(e, OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0, -1, 32'd0);
    e = blank("beq"); e.jmp = 1'b1; e.tgt = 32'h140;
    run(e, OP_BR, 3'b000, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, -1, 32'd0);
    e = blank("bge_nt");
    run(e, OP_BR, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h100, 32'd0, -1, 32'd0);
    e = blank("br_f3_010"); e.ill = 1'b1;
    run(e, OP_BR, 3'b010, 32'd5, 32'd5, 32'h40, 32'h100, 32'd0, -1, 32'd0);

    e = blank("jal"); e.rf_we = 1'b1; e.wdata = 32'h204; e.jmp = 1'b1; e.tgt = 32'h210;
    run(e, OP_JAL, 3'b000, 32'd0, 32'd0, 32'h10, 32'h200, 32'd0, -1, 32'd0);
    e = blank("jalr"); e.rf_we = 1'b1; e.wdata = 32'h404; e.jmp = 1'b1; e.tgt = 32'h310;
    run(e, OP_JALR, 3'b000, 32'h301, 32'd0, 32'h10, 32'h400, 32'd0, -1, 32'd0);
    e = blank("lui"); e.rf_we = 1'b1; e.wdata = 32'hABCD_E000;
    run(e, OP_LUI, 3'b000, 32'd0, 32'd0, 32'hABCD_E000, 32'h0, 32'd0, -1, 32'd0);
    e = blank("auipc"); e.rf_we = 1'b1; e.wdata = 32'h3000;
    run(e, OP_AUIPC, 3'b000, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'd0, -1, 32'd0);

    e = blank("lb"); e.rf_we = 1'b1; e.wdata = 32'hFFFF_FF80; e.lat = 3; e.reqs = 1;
    e.be = 4'b0100; e.addr = 32'h1002;
    run(e, OP_LOAD, 3'b000, 32'h1000, 32'd0, 32'd2, 32'h0, 32'd0, 0, 32'h0080_0000);
    e = blank("lbu"); e.rf_we = 1'b1; e.wdata = 32'h0000_0080; e.lat = 3; e.reqs = 1;
    e.be = 4'b0100; e.addr = 32'h1002;
    run(e, OP_LOAD, 3'b100, 32'h1000, 32'd0, 32'd2, 32'h0, 32'd0, 0, 32'h0080_0000);
    e = blank("sh"); e.lat = 6; e.reqs = 4; e.we = 1'b1; e.be = 4'b1100;
    e.addr = 32'h1002; e.mwdata = 32'hABCD_ABCD;
    run(e, OP_STORE, 3'b001, 32'h1000, 32'h0000_ABCD, 32'd2, 32'h0, 32'd0, 3, 32'd0);
    e = blank("sb"); e.lat = 4; e.reqs = 2; e.we = 1'b1; e.be = 4'b1000;
    e.addr = 32'h1003; e.mwdata = 32'h5A5A_5A5A;
    run(e, OP_STORE, 3'b000, 32'h1003, 32'h0000_005A, 32'd0, 32'h0, 32'd0, 1, 32'd0);
    e = blank("lw"); e.rf_we = 1'b1; e.wdata = 32'hDEAD_BEEF; e.lat = 4; e.reqs = 2;
    e.be = 4'hF; e.addr = 32'h2000;
    run(e, OP_LOAD, 3'b010, 32'h2000, 32'd0, 32'd0, 32'h0, 32'd0, 1, 32'hDEAD_BEEF);
    e = blank("lh_ack_at_limit"); e.rf_we = 1'b1; e.wdata = 32'hFFFF_8001; e.lat = 6;
    e.reqs = 4; e.be = 4'b1100; e.addr = 32'h2002;
    run(e, OP_LOAD, 3'b001, 32'h2000, 32'd0, 32'd2, 32'h0, 32'd0, 3, 32'h8001_0000);
    e = blank("timeout"); e.err = 1'b1; e.lat = 6; e.reqs = 4; e.be = 4'hF; e.addr = 32'h3000;
    run(e, OP_LOAD, 3'b010, 32'h3000, 32'd0, 32'd0, 32'h0, 32'd0, -1, 32'd0);
    e = blank("bad_opcode"); e.ill = 1'b1;
    run(e, 7'b1111111, 3'b000, 32'd0, 32'd0, 32'd0, 32'h0, 32'd0, -1, 32'd0);
    e = blank("ld_rv32"); e.ill = 1'b1;
    run(e, OP_LOAD, 3'b011, 32'h2000, 32'd0, 32'd0, 32'h0, 32'd0, 0, 32'd0);

`ifdef MISALIGN_TRAP_EN
    e = blank("lw_mis"); e.mis = 1'b1;
    run(e, OP_LOAD, 3'b010, 32'h1001, 32'd0, 32'd0, 32'h0, 32'd0, 0, 32'h1122_3344);
    e = blank("jalr_mis"); e.mis = 1'b1;
    run(e, OP_JALR, 3'b000, 32'h202, 32'd0, 32'd0, 32'h500, 32'd0, -1, 32'd0);
`else
    e = blank("lw_mis"); e.rf_we = 1'b1; e.wdata = 32'h0011_2233; e.lat = 3; e.reqs = 1;
    e.be = 4'b1110; e.addr = 32'h1001;
    run(e, OP_LOAD, 3'b010, 32'h1001, 32'd0, 32'd0, 32'h0, 32'd0, 0, 32'h1122_3344);
    e = blank("jalr_mis"); e.rf_we = 1'b1; e.wdata = 32'h504; e.jmp = 1'b1; e.tgt = 32'h202;
    run(e, OP_JALR, 3'b000, 32'h202, 32'd0, 32'd0, 32'h500, 32'd0, -1, 32'd0);
`endif

    // Reset while a load is waiting in MEM, then a stray ack in IDLE.
    opcode = OP_LOAD; funct3 = 3'b010; rs1_val = 32'h4000; imm = 32'd0;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (!mem_if.mem_req && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmem.req_seen", mem_if.mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmem.req", mem_if.mem_req, 1'b0);
    chk("rstmem.ready", instr_ready, 1'b1);
    chk("rstmem.rf_we", rf_we, 1'b0);
    chk("rstmem.done", done, 1'b0);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0;
    chk("idle_ack.done", done, 1'b0);
    chk("idle_ack.rf_we", rf_we, 1'b0);
    chk("idle_ack.ready", instr_ready, 1'b1);
    chk("scoreboard.empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
